// File: rtl/wb_write_arbiter_pkg.sv
// wb_write_arbiter: shared register-file types, constants
// and the write-slot selector encoding.
package wb_write_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;

  localparam reg_data_t ZERO_WORD = '0;
  localparam reg_addr_t REG_ZERO = '0;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef struct packed {
    logic      vld;
    reg_addr_t addr;
    reg_data_t data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_PIPE,
    SEL_LATE
  } wb_sel_e;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// wb_write_arbiter: pipeline write-back, late-result
// handshake and register-file write port bundle.
interface wb_write_arbiter_if #(
  parameter int DEPTH = 4
);
  import wb_write_arbiter_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic          pipe_we;
  reg_addr_t     pipe_waddr;
  reg_data_t     pipe_wdata;
  logic          late_valid;
  logic          late_ready;
  reg_addr_t     late_waddr;
  reg_data_t     late_wdata;
  logic          we;
  reg_addr_t     waddr;
  reg_data_t     wdata;
  logic [CW-1:0] pending;
  logic          stallreq;

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata,
    output late_valid, late_waddr, late_wdata,
    input  late_ready,
    input  we, waddr, wdata,
    input  pending, stallreq
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  late_valid, late_waddr, late_wdata,
    output late_ready,
    output we, waddr, wdata,
    output pending, stallreq
  );

endinterface

// File: rtl/wb_pending_fifo.sv
// Pending queue for late write-backs: compacting FIFO
// with per-entry valid, kill-by-address and live count.
module wb_pending_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  wb_entry_t     i_push_ent,
  input  logic          i_pop,
  input  logic          i_kill,
  input  reg_addr_t     i_kill_addr,
  output wb_entry_t     o_head,
  output logic [CW-1:0] o_count
);

  wb_entry_t     r_ent [DEPTH];
  wb_entry_t     w_ent [DEPTH];
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt;
  logic          w_keep;

  // Survivors slide toward index 0 so live entries stay
  // contiguous and the head is always slot 0.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_ent[i] = '0;
    end
    w_cnt = '0;
    w_keep = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_keep = r_ent[i].vld
        && !(i_pop && (i == 0))
        && !(i_kill && (r_ent[i].addr == i_kill_addr));
      if (w_keep) begin
        w_ent[w_cnt[AW-1:0]] = r_ent[i];
        w_cnt = w_cnt + CW'(1);
      end
    end
    if (i_push
        && !(i_kill && (i_push_ent.addr == i_kill_addr))) begin
      w_ent[w_cnt[AW-1:0]] = i_push_ent;
      w_cnt = w_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ent <= '{default: '0};
      r_cnt <= '0;
    end else begin
      r_ent <= w_ent;
      r_cnt <= w_cnt;
    end
  end

  assign o_head  = r_ent[0];
  assign o_count = r_cnt;

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write port owner: pipeline writes first,
// queued late results drain into idle slots.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic clk,
  input logic rst,
  wb_write_arbiter_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  wb_entry_t     w_head;
  wb_entry_t     w_push_ent;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_ready;
  logic          w_accept;
  logic          w_push;
  logic          w_pipe;
  logic          w_pop;
  wb_sel_e       w_sel;

  logic          r_we;
  reg_addr_t     r_waddr;
  reg_data_t     r_wdata;
  logic [SW-1:0] r_starve;

  assign w_full   = (w_count == FULL);
  assign w_ready  = !rst && !w_full;
  assign w_accept = bus.late_valid && w_ready;
  // r0 results complete the handshake but never land.
  assign w_push   = w_accept
    && (bus.late_waddr != REG_ZERO);
  assign w_push_ent = '{
    vld:  1'b1,
    addr: bus.late_waddr,
    data: bus.late_wdata
  };
  assign w_pipe = bus.pipe_we
    && (bus.pipe_waddr != REG_ZERO);
  assign w_pop  = (w_sel == SEL_LATE);

  always_comb begin
    w_sel = SEL_IDLE;
    unique case (1'b1)
      w_pipe:                w_sel = SEL_PIPE;
      !w_pipe && w_head.vld: w_sel = SEL_LATE;
      default:               w_sel = SEL_IDLE;
    endcase
  end

  wb_pending_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_ent  (w_push_ent),
    .i_pop       (w_pop),
    .i_kill      (w_pipe),
    .i_kill_addr (bus.pipe_waddr),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= WRITE_DISABLE;
      r_waddr <= REG_ZERO;
      r_wdata <= ZERO_WORD;
    end else begin
      r_we <= WRITE_DISABLE;
      unique case (w_sel)
        SEL_PIPE: begin
          r_we    <= WRITE_ENABLE;
          r_waddr <= bus.pipe_waddr;
          r_wdata <= bus.pipe_wdata;
        end
        SEL_LATE: begin
          r_we    <= WRITE_ENABLE;
          r_waddr <= w_head.addr;
          r_wdata <= w_head.data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (!w_head.vld || w_pop) begin
      r_starve <= '0;
    end else if (r_starve < SLIM) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  assign bus.we         = r_we;
  assign bus.waddr      = r_waddr;
  assign bus.wdata      = r_wdata;
  assign bus.pending    = w_count;
  assign bus.late_ready = w_ready;
  assign bus.stallreq   = (r_starve >= SLIM || w_full)
    ? STOP : NO_STOP;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter with a queue model
// and an expected-write scoreboard.
module tb_wb_write_arbiter;
  import wb_write_arbiter_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  wr_t exp_q[$];
  wr_t mq[$];
  int st = 0;

  wb_write_arbiter_if #(.DEPTH(DEPTH)) bus();

  wb_write_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  // Every issued write is popped from the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (bus.we === 1'b1) begin
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_errors++;
        $error("FAIL spurious_write: observed r%0d=%0h expected none",
               bus.waddr, bus.wdata);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        assert ({bus.waddr, bus.wdata} === {e.a, e.d}) else begin
          n_errors++;
          $error("FAIL write_order: observed r%0d=%0h expected r%0d=%0h",
                 bus.waddr, bus.wdata, e.a, e.d);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.pipe_we    = 1'b0;
    bus.pipe_waddr = 5'd0;
    bus.pipe_wdata = 32'd0;
    bus.late_valid = 1'b0;
    bus.late_waddr = 5'd0;
    bus.late_wdata = 32'd0;
  endtask

  task automatic step(input logic pv, input logic [4:0] pa,
                      input logic [31:0] pd, input logic lv,
                      input logic [4:0] la, input logic [31:0] ld);
    int pre;
    bit rdy;
    bit issue;
    bit popped;
    wr_t w;
    bus.pipe_we    = pv;
    bus.pipe_waddr = pa;
    bus.pipe_wdata = pd;
    bus.late_valid = lv;
    bus.late_waddr = la;
    bus.late_wdata = ld;
    pre = mq.size();
    rdy = (pre < DEPTH);
    issue = pv && (pa != 5'd0);
    popped = 1'b0;
    if (issue) begin
      w.a = pa;
      w.d = pd;
      exp_q.push_back(w);
      for (int i = mq.size() - 1; i >= 0; i--)
        if (mq[i].a == pa) mq.delete(i);
    end else if (pre > 0) begin
      exp_q.push_back(mq.pop_front());
      popped = 1'b1;
    end
    if (lv && rdy && la != 5'd0 && !(issue && la == pa)) begin
      w.a = la;
      w.d = ld;
      mq.push_back(w);
    end
    if (pre == 0 || popped) st = 0;
    else if (st < LIMIT) st++;
    @(posedge clk);
    #1;
    chk("pending", 32'(bus.pending), 32'(mq.size()));
    chk("late_ready", 32'(bus.late_ready),
        32'(mq.size() < DEPTH));
    chk("stallreq", 32'(bus.stallreq),
        32'(st >= LIMIT || mq.size() == DEPTH));
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    mq.delete();
    st = 0;
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_waddr", 32'(bus.waddr), 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_stallreq", 32'(bus.stallreq), 32'd0);
    chk("rst_late_ready", 32'(bus.late_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_late_ready", 32'(bus.late_ready), 32'd1);
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // 1: pipe only, r0 is an idle slot
    step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    chk("t1_we", 32'(bus.we), 32'd1);
    chk("t1_waddr", 32'(bus.waddr), 32'd5);
    chk("t1_wdata", bus.wdata, 32'h1234);
    step(1'b1, 5'd0, 32'hdead, 1'b0, 5'd0, 32'd0);
    chk("t1_r0_we", 32'(bus.we), 32'd0);
    chk("t1_hold_waddr", 32'(bus.waddr), 32'd5);

    // 2: late result through an idle slot
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA);
    chk("t2_pend1", 32'(bus.pending), 32'd1);
    chk("t2_no_bypass", 32'(bus.we), 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t2_we", 32'(bus.we), 32'd1);
    chk("t2_waddr", 32'(bus.waddr), 32'd7);
    chk("t2_wdata", bus.wdata, 32'hAA);
    chk("t2_pend0", 32'(bus.pending), 32'd0);

    // 3: contention fills the queue, then drains in order
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'(10 + i), 32'h1000 + i,
           1'b1, 5'(20 + i), 32'h2000 + i);
    chk("t3_full", 32'(bus.pending), 32'd4);
    chk("t3_ready0", 32'(bus.late_ready), 32'd0);
    chk("t3_stall", 32'(bus.stallreq), 32'd1);
    step(1'b1, 5'd14, 32'h1004, 1'b1, 5'd25, 32'h2005);
    chk("t3_refused", 32'(bus.pending), 32'd4);
    for (int i = 0; i < 4; i++)
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t3_last_waddr", 32'(bus.waddr), 32'd23);
    chk("t3_empty", 32'(bus.pending), 32'd0);

    // 4: starvation under continuous pipe writes
    step(1'b1, 5'd1, 32'h3001, 1'b1, 5'd12, 32'hC0);
    for (int i = 2; i <= 9; i++) begin
      step(1'b1, 5'(i), 32'h3000 + i, 1'b0, 5'd0, 32'd0);
      if (i == 8) chk("t4_stall_7", 32'(bus.stallreq), 32'd0);
      if (i == 9) chk("t4_stall_8", 32'(bus.stallreq), 32'd1);
    end
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t4_drain_waddr", 32'(bus.waddr), 32'd12);
    chk("t4_drain_wdata", bus.wdata, 32'hC0);
    chk("t4_stall_clr", 32'(bus.stallreq), 32'd0);

    // 5: WAW kill, queued and same-cycle
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h11);
    chk("t5_queued", 32'(bus.pending), 32'd1);
    step(1'b1, 5'd3, 32'h22, 1'b0, 5'd0, 32'd0);
    chk("t5_killed", 32'(bus.pending), 32'd0);
    chk("t5_wdata", bus.wdata, 32'h22);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t5_no_stale", 32'(bus.we), 32'd0);
    step(1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 32'h44);
    chk("t5_same_cyc", 32'(bus.pending), 32'd0);
    chk("t5_same_wdata", bus.wdata, 32'h33);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    chk("t5_r0_late", 32'(bus.pending), 32'd0);
    chk("t5_r0_we", 32'(bus.we), 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t5_r0_never", 32'(bus.we), 32'd0);

    // 6: reset mid-drain loses queued results
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'(1 + i), 32'h4000 + i,
           1'b1, 5'(4 + i), 32'h5000 + i);
    chk("t6_pend3", 32'(bus.pending), 32'd3);
    do_reset();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t6_no_drain", 32'(bus.we), 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
